id_operand_stage: RTL and testbench
===================================

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 reset  in  1  reset is asynchronous and active-low; all state cleared while reset=0.
REQ-003 instr  in  32  MIPS instruction from fetch; instr_valid  in  1  instr present; id_ready  out  1  instr accepted this cycle.
REQ-004 r1sel, r2sel  out  5  register-file read selects (combinational, = instr[25:21], instr[20:16]); reg1, reg2  in  32  register-file read data.
REQ-005 exm_we  in  1, exm_wsel  in  5, exm_data  in  32, exm_pending  in  1  forward source from the stage after this block's output register; pending=1 means exm_data not yet valid (load in flight).
REQ-006 wb_we  in  1, wb_wsel  in  5, wb_data  in  32  write-back source (same values driven to register-file write port).
REQ-007 flush  in  1  synchronous discard of the output register and the presented instruction.
REQ-008 ex_ready  in  1  downstream accepts; ex_valid  out  1  output register holds an instruction.
REQ-009 ex_opa, ex_opb, ex_sdata  out  32  operand A, operand B, store data; ex_imm  out  32  extended immediate.
REQ-010 ex_opcode, ex_funct  out  6  instr[31:26], instr[5:0]; ex_dest  out  5; ex_wen, ex_load, ex_store, ex_illegal  out  1.

Function
REQ-011 Decode: opcode 0x00 R-type (dest=rd, uses rs,rt); 0x08,0x09,0x0A,0x0C,0x0D,0x0F ALU-imm (dest=rt, uses rs); 0x23 LW (dest=rt, uses rs, load); 0x2B SW (uses rs,rt, store, no write); 0x04,0x05 branch (uses rs,rt, no write).
REQ-012 Any other opcode: ex_illegal=1, ex_wen=0, ex_load=0, ex_store=0, no source used.
REQ-013 ex_wen=1 only for writing classes with dest != 0; ex_dest=0 when ex_wen=0.
REQ-014 Immediate: sign-extend instr[15:0] for 0x08,0x09,0x0A,0x23,0x2B,0x04,0x05; zero-extend for 0x0C,0x0D; {instr[15:0],16'h0} for 0x0F; 0 for R-type/illegal.
REQ-015 ex_opa=value(rs); ex_opb=value(rt) for R-type/branch/SW, ex_imm otherwise; ex_sdata=value(rt) for SW, else 0.
REQ-016 Operand value(r), priority: r=0 -> 0; exm_we && exm_wsel=r -> exm_data; wb_we && wb_wsel=r -> wb_data; else regfile read.
REQ-017 advance = !ex_valid || ex_ready.
REQ-018 hazard (combinational) = instr_valid && (load-use || exm-pending): load-use = ex_valid && ex_load && ex_dest!=0 && ex_dest equals a used source; exm-pending = exm_pending && exm_we && exm_wsel!=0 && exm_wsel equals a used source.
REQ-019 id_ready = flush || (advance && !hazard).
REQ-020 Edge with flush=1: ex_valid<=0, other ex_* unchanged; presented instr discarded; flush overrides all else.
REQ-021 Edge with advance && instr_valid && !hazard: load decoded instr and operands, ex_valid<=1.
REQ-022 Edge with advance && (hazard || !instr_valid): bubble, ex_valid<=0; instr not accepted and is re-presented by fetch.
REQ-023 Edge with !advance: output register holds all values; id_ready=0.
REQ-024 Latency: one cycle from accept to ex_valid; load-use costs exactly one bubble when exm_pending is 0 on the following cycle.
REQ-025 ex_* outputs driven from registers only; no combinational path from instr to ex_*.

Reset
REQ-026 reset=0 asynchronously forces ex_valid=0 and every other ex_* output to 0, independent of clk.
REQ-027 Release of reset mid-stall: first cycle after release behaves as empty output register (advance=1).
REQ-028 id_ready during reset is don't-care; bench shall not present instructions.

Verification
REQ-029 ADDI $t0,$zero,5 (0x20080005), ex_ready=1 -> next cycle ex_valid=1, ex_dest=8, ex_opa=0, ex_opb=5, ex_wen=1.
REQ-030 LW $t1,0($t0) then ADD $t2,$t1,$t1 -> one cycle ex_valid=0 with id_ready=0, then ADD issued with operands from exm_data when exm_wsel=9.
REQ-031 wb_we=1, wb_wsel=3, wb_data=0xDEADBEEF, reg1=0, instr OR rd=4,rs=3,rt=0 -> ex_opa=0xDEADBEEF, ex_opb=0.
REQ-032 ORI $t0,$zero,0x8000 -> ex_imm=0x00008000; ADDI same imm -> ex_imm=0xFFFF8000; LUI 0x1234 -> ex_imm=0x12340000.
REQ-033 ex_valid=1, ex_ready=0 for 3 cycles -> ex_* stable, id_ready=0; flush=1 -> next cycle ex_valid=0, id_ready=1 that cycle.
REQ-034 opcode 0x3F -> ex_illegal=1, ex_wen=0; ADD rd=0 -> ex_wen=0, ex_dest=0; reset=0 asserted mid-stream -> ex_valid=0 immediately.

Source files
------------

// File: rtl/id_operand_stage_if.sv
// Bundles the fetch-side, forwarding, register-file and EX-side signals of the
// operand stage so that they can be passed as a single port.
// slave: the operand stage's view. master: the surrounding pipeline (or bench) view.
//   fetch  : instr, instr_valid -> / <- id_ready
//   regfile: <- r1sel, r2sel / reg1, reg2 ->
//   fwd    : exm_we/wsel/data/pending, wb_we/wsel/data ->
//   ex     : flush, ex_ready -> / <- ex_valid, ex_opa/opb/sdata/imm, ex_opcode/funct,
//            ex_dest, ex_wen, ex_load, ex_store, ex_illegal
interface id_operand_stage_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        id_ready;

  logic [4:0]  r1sel;
  logic [4:0]  r2sel;
  logic [31:0] reg1;
  logic [31:0] reg2;

  logic        exm_we;
  logic [4:0]  exm_wsel;
  logic [31:0] exm_data;
  logic        exm_pending;

  logic        wb_we;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_data;

  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_opa;
  logic [31:0] ex_opb;
  logic [31:0] ex_sdata;
  logic [31:0] ex_imm;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_dest;
  logic        ex_wen;
  logic        ex_load;
  logic        ex_store;
  logic        ex_illegal;

  modport slave (
    input  instr, instr_valid, reg1, reg2,
    input  exm_we, exm_wsel, exm_data, exm_pending,
    input  wb_we, wb_wsel, wb_data, flush, ex_ready,
    output id_ready, r1sel, r2sel,
    output ex_valid, ex_opa, ex_opb, ex_sdata, ex_imm, ex_opcode, ex_funct,
    output ex_dest, ex_wen, ex_load, ex_store, ex_illegal
  );

  modport master (
    output instr, instr_valid, reg1, reg2,
    output exm_we, exm_wsel, exm_data, exm_pending,
    output wb_we, wb_wsel, wb_data, flush, ex_ready,
    input  id_ready, r1sel, r2sel,
    input  ex_valid, ex_opa, ex_opb, ex_sdata, ex_imm, ex_opcode, ex_funct,
    input  ex_dest, ex_wen, ex_load, ex_store, ex_illegal
  );
endinterface

// File: rtl/id_operand_stage.sv
// MIPS decode / operand-fetch stage with EXM and WB forwarding and load-use interlock.
// Latency: one cycle from instr acceptance to ex_valid; load-use inserts one bubble.
// Backpressure: output register holds while ex_valid && !ex_ready; id_ready drops on hold or hazard.
// Ports: clk, reset (async active-low), bus (id_operand_stage_if.slave) carrying
// fetch handshake, register-file selects/data, forwarding sources, flush and EX outputs.
module id_operand_stage (
  input  logic              clk,
  input  logic              reset,
  id_operand_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  assign op    = bus.instr[31:26];
  assign rs    = bus.instr[25:21];
  assign rt    = bus.instr[20:16];
  assign rd    = bus.instr[15:11];
  assign imm16 = bus.instr[15:0];

  assign bus.r1sel = rs;
  assign bus.r2sel = rt;

  // Decode of the presented instruction.
  logic        uses_rs, uses_rt, writes, is_load, is_store, is_illegal, opb_is_rt;
  logic [4:0]  dest_raw;
  logic [31:0] imm_d;

  always_comb begin
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    writes     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_illegal = 1'b0;
    opb_is_rt  = 1'b0;
    dest_raw   = 5'd0;
    imm_d      = 32'd0;
    case (op)
      OP_RTYPE: begin
        uses_rs = 1'b1; uses_rt = 1'b1; writes = 1'b1; dest_raw = rd; opb_is_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        uses_rs = 1'b1; writes = 1'b1; dest_raw = rt; imm_d = {{16{imm16[15]}}, imm16};
      end
      OP_ANDI, OP_ORI: begin
        uses_rs = 1'b1; writes = 1'b1; dest_raw = rt; imm_d = {16'h0, imm16};
      end
      OP_LUI: begin
        uses_rs = 1'b1; writes = 1'b1; dest_raw = rt; imm_d = {imm16, 16'h0};
      end
      OP_LW: begin
        uses_rs = 1'b1; writes = 1'b1; dest_raw = rt; is_load = 1'b1;
        imm_d = {{16{imm16[15]}}, imm16};
      end
      OP_SW: begin
        uses_rs = 1'b1; uses_rt = 1'b1; is_store = 1'b1; opb_is_rt = 1'b1;
        imm_d = {{16{imm16[15]}}, imm16};
      end
      OP_BEQ, OP_BNE: begin
        uses_rs = 1'b1; uses_rt = 1'b1; opb_is_rt = 1'b1;
        imm_d = {{16{imm16[15]}}, imm16};
      end
      default: is_illegal = 1'b1;
    endcase
  end

  logic       wen_d;
  logic [4:0] dest_d;
  assign wen_d  = writes && (dest_raw != 5'd0);
  assign dest_d = wen_d ? dest_raw : 5'd0;

  // Operand resolution: $zero, then the younger EXM result, then WB, then regfile.
  function automatic logic [31:0] operand(
    input logic [4:0]  r,
    input logic [31:0] rf,
    input logic        m_we,
    input logic [4:0]  m_sel,
    input logic [31:0] m_dat,
    input logic        w_we,
    input logic [4:0]  w_sel,
    input logic [31:0] w_dat
  );
    if (r == 5'd0)                 operand = 32'd0;
    else if (m_we && m_sel == r)   operand = m_dat;
    else if (w_we && w_sel == r)   operand = w_dat;
    else                           operand = rf;
  endfunction

  logic [31:0] rs_val, rt_val, opb_d, sdata_d;
  assign rs_val  = operand(rs, bus.reg1, bus.exm_we, bus.exm_wsel, bus.exm_data,
                           bus.wb_we, bus.wb_wsel, bus.wb_data);
  assign rt_val  = operand(rt, bus.reg2, bus.exm_we, bus.exm_wsel, bus.exm_data,
                           bus.wb_we, bus.wb_wsel, bus.wb_data);
  assign opb_d   = opb_is_rt ? rt_val : imm_d;
  assign sdata_d = is_store ? rt_val : 32'd0;

  // Output register.
  logic        valid_q, wen_q, load_q, store_q, illegal_q;
  logic [31:0] opa_q, opb_q, sdata_q, imm_q;
  logic [5:0]  opcode_q, funct_q;
  logic [4:0]  dest_q;

  // Load-use: the load sitting in our output register has no data yet.
  // EXM-pending: the instruction one stage further on is still waiting for memory.
  logic load_use, exm_wait, hazard, advance;
  assign load_use = valid_q && load_q && (dest_q != 5'd0) &&
                    ((uses_rs && dest_q == rs) || (uses_rt && dest_q == rt));
  assign exm_wait = bus.exm_pending && bus.exm_we && (bus.exm_wsel != 5'd0) &&
                    ((uses_rs && bus.exm_wsel == rs) || (uses_rt && bus.exm_wsel == rt));
  assign hazard   = bus.instr_valid && (load_use || exm_wait);
  assign advance  = !valid_q || bus.ex_ready;

  // A flush discards the presented instruction, so fetch sees it as consumed.
  assign bus.id_ready = bus.flush || (advance && !hazard);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      sdata_q   <= 32'd0;
      imm_q     <= 32'd0;
      opcode_q  <= 6'd0;
      funct_q   <= 6'd0;
      dest_q    <= 5'd0;
      wen_q     <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      if (bus.instr_valid && !hazard) begin
        valid_q   <= 1'b1;
        opa_q     <= rs_val;
        opb_q     <= opb_d;
        sdata_q   <= sdata_d;
        imm_q     <= imm_d;
        opcode_q  <= op;
        funct_q   <= bus.instr[5:0];
        dest_q    <= dest_d;
        wen_q     <= wen_d;
        load_q    <= is_load;
        store_q   <= is_store;
        illegal_q <= is_illegal;
      end else begin
        // Bubble: payload fields are left as-is, only the valid bit drops.
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_opa     = opa_q;
  assign bus.ex_opb     = opb_q;
  assign bus.ex_sdata   = sdata_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_opcode  = opcode_q;
  assign bus.ex_funct   = funct_q;
  assign bus.ex_dest    = dest_q;
  assign bus.ex_wen     = wen_q;
  assign bus.ex_load    = load_q;
  assign bus.ex_store   = store_q;
  assign bus.ex_illegal = illegal_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized and directed bench for id_operand_stage against an instruction-level model.
module tb_id_operand_stage;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_operand_stage_if bus();

  id_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] sdata;
    logic [31:0] imm;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  dest;
    logic        wen;
    logic        load;
    logic        store;
    logic        illegal;
  } ex_t;

  typedef enum {K_R, K_ALUI, K_LW, K_SW, K_BR, K_ILL} kind_e;

  int checks = 0;
  int errors = 0;

  ex_t  m;          // model of the output register
  ex_t  held;
  logic obs_rdy, exp_rdy;
  logic [4:0] obs_r1, obs_r2;

  function automatic kind_e m_kind(input logic [5:0] op);
    case (op)
      6'h00:                      return K_R;
      6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0F:        return K_ALUI;
      6'h23:                      return K_LW;
      6'h2B:                      return K_SW;
      6'h04, 6'h05:               return K_BR;
      default:                    return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] m_val(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'd0;
    if (bus.exm_we && bus.exm_wsel == r) return bus.exm_data;
    if (bus.wb_we && bus.wb_wsel == r) return bus.wb_data;
    return rf;
  endfunction

  function automatic ex_t m_issue();
    ex_t e;
    kind_e k;
    logic [15:0] i16;
    logic [5:0]  op;
    logic [4:0]  d;
    logic [31:0] rtv;
    op  = bus.instr[31:26];
    i16 = bus.instr[15:0];
    k   = m_kind(op);
    e = '0;
    e.valid  = 1'b1;
    e.opcode = op;
    e.funct  = bus.instr[5:0];
    if (op inside {6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05}) e.imm = int'(shortint'(i16));
    else if (op inside {6'h0C, 6'h0D}) e.imm = 32'(i16);
    else if (op == 6'h0F) e.imm = 32'(i16) << 16;
    else e.imm = 32'd0;
    d = (k == K_R) ? bus.instr[15:11] : bus.instr[20:16];
    e.wen     = (k inside {K_R, K_ALUI, K_LW}) && d != 0;
    e.dest    = e.wen ? d : 5'd0;
    e.load    = (k == K_LW);
    e.store   = (k == K_SW);
    e.illegal = (k == K_ILL);
    e.opa     = m_val(bus.instr[25:21], bus.reg1);
    rtv       = m_val(bus.instr[20:16], bus.reg2);
    e.opb     = (k inside {K_R, K_BR, K_SW}) ? rtv : e.imm;
    e.sdata   = (k == K_SW) ? rtv : 32'd0;
    return e;
  endfunction

  function automatic logic m_hazard();
    kind_e k;
    logic urs, urt, lu, ep;
    logic [4:0] rs, rt;
    k   = m_kind(bus.instr[31:26]);
    rs  = bus.instr[25:21];
    rt  = bus.instr[20:16];
    urs = (k != K_ILL);
    urt = (k inside {K_R, K_SW, K_BR});
    lu  = m.valid && m.load && m.dest != 0 && ((urs && m.dest == rs) || (urt && m.dest == rt));
    ep  = bus.exm_pending && bus.exm_we && bus.exm_wsel != 0 &&
          ((urs && bus.exm_wsel == rs) || (urt && bus.exm_wsel == rt));
    return bus.instr_valid && (lu || ep);
  endfunction

  function automatic ex_t dut_ex();
    ex_t a;
    a.valid   = bus.ex_valid;
    a.opa     = bus.ex_opa;
    a.opb     = bus.ex_opb;
    a.sdata   = bus.ex_sdata;
    a.imm     = bus.ex_imm;
    a.opcode  = bus.ex_opcode;
    a.funct   = bus.ex_funct;
    a.dest    = bus.ex_dest;
    a.wen     = bus.ex_wen;
    a.load    = bus.ex_load;
    a.store   = bus.ex_store;
    a.illegal = bus.ex_illegal;
    return a;
  endfunction

  task automatic set_idle();
    bus.instr       = 32'd0;
    bus.instr_valid = 1'b0;
    bus.reg1        = $urandom;
    bus.reg2        = $urandom;
    bus.exm_we      = 1'b0;
    bus.exm_wsel    = 5'd0;
    bus.exm_data    = 32'd0;
    bus.exm_pending = 1'b0;
    bus.wb_we       = 1'b0;
    bus.wb_wsel     = 5'd0;
    bus.wb_data     = 32'd0;
    bus.flush       = 1'b0;
    bus.ex_ready    = 1'b1;
  endtask

  // Applies the current inputs for one cycle (called at negedge), records the
  // combinational outputs, and advances the model across the clock edge.
  task automatic step();
    ex_t nxt;
    logic adv, haz;
    #1;
    obs_rdy = bus.id_ready;
    obs_r1  = bus.r1sel;
    obs_r2  = bus.r2sel;
    adv = !m.valid || bus.ex_ready;
    haz = m_hazard();
    exp_rdy = bus.flush || (adv && !haz);
    nxt = m;
    if (bus.flush) nxt.valid = 1'b0;
    else if (adv) begin
      if (bus.instr_valid && !haz) nxt = m_issue();
      else nxt.valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m = nxt;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins);
    set_idle();
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    step();
  endtask

  task automatic test_reset();
    set_idle();
    m = '0;
    #12;
    checks++;
    if (dut_ex() !== ex_t'('0)) begin
      errors++; $display("FAIL reset_state got %h want 0", dut_ex());
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_addi();
    issue(32'h2008_0005);
    checks++;
    if (obs_rdy !== 1'b1 || obs_r1 !== 5'd0 || obs_r2 !== 5'd8) begin
      errors++; $display("FAIL addi_accept rdy=%b r1=%0d r2=%0d want 1 0 8", obs_rdy, obs_r1, obs_r2);
    end
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd8 || bus.ex_opa !== 32'd0 ||
        bus.ex_opb !== 32'd5 || bus.ex_wen !== 1'b1) begin
      errors++; $display("FAIL addi_out v=%b dest=%0d opa=%h opb=%h wen=%b want 1 8 0 5 1",
                         bus.ex_valid, bus.ex_dest, bus.ex_opa, bus.ex_opb, bus.ex_wen);
    end
    checks++;
    if (dut_ex() !== m) begin
      errors++; $display("FAIL addi_model got %h want %h", dut_ex(), m);
    end
  endtask

  task automatic test_imm();
    logic [31:0] ins [3];
    logic [31:0] want [3];
    ins[0] = 32'h3408_8000; want[0] = 32'h0000_8000;
    ins[1] = 32'h2008_8000; want[1] = 32'hFFFF_8000;
    ins[2] = 32'h3C08_1234; want[2] = 32'h1234_0000;
    for (int i = 0; i < 3; i++) begin
      issue(ins[i]);
      checks++;
      if (bus.ex_imm !== want[i] || bus.ex_opb !== want[i]) begin
        errors++; $display("FAIL imm_%0d imm=%h opb=%h want %h", i, bus.ex_imm, bus.ex_opb, want[i]);
      end
    end
  endtask

  task automatic test_wb_fwd();
    set_idle();
    bus.instr = 32'h0060_2025;   // OR $4,$3,$0
    bus.instr_valid = 1'b1;
    bus.reg1 = 32'd0;
    bus.wb_we = 1'b1; bus.wb_wsel = 5'd3; bus.wb_data = 32'hDEAD_BEEF;
    step();
    checks++;
    if (bus.ex_opa !== 32'hDEAD_BEEF || bus.ex_opb !== 32'd0 || bus.ex_dest !== 5'd4) begin
      errors++; $display("FAIL wb_fwd opa=%h opb=%h dest=%0d want deadbeef 0 4",
                         bus.ex_opa, bus.ex_opb, bus.ex_dest);
    end
  endtask

  task automatic test_load_use();
    issue(32'h8D09_0000);        // LW $9,0($8)
    set_idle();
    bus.instr = 32'h0129_5020;   // ADD $10,$9,$9
    bus.instr_valid = 1'b1;
    step();
    checks++;
    if (obs_rdy !== 1'b0 || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble rdy=%b v=%b want 0 0", obs_rdy, bus.ex_valid);
    end
    bus.exm_we = 1'b1; bus.exm_wsel = 5'd9; bus.exm_data = 32'hCAFE_0123; bus.exm_pending = 1'b0;
    step();
    checks++;
    if (obs_rdy !== 1'b1 || bus.ex_valid !== 1'b1 || bus.ex_opa !== 32'hCAFE_0123 ||
        bus.ex_opb !== 32'hCAFE_0123 || bus.ex_dest !== 5'd10) begin
      errors++; $display("FAIL load_use_issue rdy=%b v=%b opa=%h opb=%h dest=%0d",
                         obs_rdy, bus.ex_valid, bus.ex_opa, bus.ex_opb, bus.ex_dest);
    end
  endtask

  task automatic test_stall_flush();
    issue(32'h2008_0077);
    held = m;
    set_idle();
    bus.instr = 32'h2009_0001;
    bus.instr_valid = 1'b1;
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_rdy !== 1'b0 || dut_ex() !== held) begin
        errors++; $display("FAIL stall_%0d rdy=%b ex=%h want 0 %h", i, obs_rdy, dut_ex(), held);
      end
    end
    bus.flush = 1'b1;
    step();
    held.valid = 1'b0;
    checks++;
    if (obs_rdy !== 1'b1 || dut_ex() !== held) begin
      errors++; $display("FAIL flush rdy=%b ex=%h want 1 %h", obs_rdy, dut_ex(), held);
    end
  endtask

  task automatic test_illegal_rd0();
    issue(32'hFC00_0000 | ($urandom & 32'h03FF_FFFF));
    checks++;
    if (bus.ex_illegal !== 1'b1 || bus.ex_wen !== 1'b0 || bus.ex_load !== 1'b0 ||
        bus.ex_store !== 1'b0 || bus.ex_imm !== 32'd0) begin
      errors++; $display("FAIL illegal ill=%b wen=%b ld=%b st=%b imm=%h", bus.ex_illegal,
                         bus.ex_wen, bus.ex_load, bus.ex_store, bus.ex_imm);
    end
    issue(32'h0129_0020);        // ADD $0,$9,$9
    checks++;
    if (bus.ex_wen !== 1'b0 || bus.ex_dest !== 5'd0 || bus.ex_valid !== 1'b1) begin
      errors++; $display("FAIL add_rd0 wen=%b dest=%0d v=%b want 0 0 1", bus.ex_wen, bus.ex_dest, bus.ex_valid);
    end
  endtask

  task automatic test_async_reset();
    issue(32'h2008_0005);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut_ex() !== ex_t'('0)) begin
      errors++; $display("FAIL async_reset got %h want 0", dut_ex());
    end
    m = '0;
    @(negedge clk);
    set_idle();
    bus.ex_ready = 1'b0;
    reset = 1'b1;
    bus.instr = 32'h2008_0009;
    bus.instr_valid = 1'b1;
    step();
    checks++;
    if (obs_rdy !== 1'b1 || bus.ex_valid !== 1'b1 || bus.ex_opb !== 32'd9) begin
      errors++; $display("FAIL reset_release rdy=%b v=%b opb=%h want 1 1 9", obs_rdy, bus.ex_valid, bus.ex_opb);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [14];
    logic [5:0] op;
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F,
            6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    for (int i = 0; i < 600; i++) begin
      op = ops[$urandom_range(0, 13)];
      bus.instr       = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 11'($urandom)};
      bus.instr_valid = ($urandom_range(0, 9) < 8);
      bus.reg1        = $urandom;
      bus.reg2        = $urandom;
      bus.exm_we      = $urandom_range(0, 1);
      bus.exm_wsel    = 5'($urandom_range(0, 3));
      bus.exm_data    = $urandom;
      bus.exm_pending = ($urandom_range(0, 4) == 0);
      bus.wb_we       = $urandom_range(0, 1);
      bus.wb_wsel     = 5'($urandom_range(0, 3));
      bus.wb_data     = $urandom;
      bus.flush       = ($urandom_range(0, 19) == 0);
      bus.ex_ready    = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (obs_rdy !== exp_rdy || obs_r1 !== bus.instr[25:21] || obs_r2 !== bus.instr[20:16]) begin
        errors++; $display("FAIL rand_rdy_%0d rdy=%b r1=%0d r2=%0d want %b %0d %0d", i, obs_rdy,
                           obs_r1, obs_r2, exp_rdy, bus.instr[25:21], bus.instr[20:16]);
      end
      checks++;
      if (dut_ex() !== m) begin
        errors++; $display("FAIL rand_ex_%0d got %h want %h", i, dut_ex(), m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_imm();
    test_wb_fwd();
    test_load_use();
    test_stall_flush();
    test_illegal_rd0();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
